// File: rtl/register_file.sv
// Parametrised CPU register file: NUM_READ read ports, one write port, register 0 reads as zero.
// Optional per-register busy scoreboard enabled by defining REGFILE_SCOREBOARD_EN.
module register_file #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_READ = 2,
    parameter int READ_LAT = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_READ*ADDR_W-1:0]   readReg,
    output logic [NUM_READ*DATA_W-1:0]   readData,
    input  logic                         writeEn,
    input  logic [ADDR_W-1:0]            writeReg,
    input  logic [DATA_W-1:0]            writeData
`ifdef REGFILE_SCOREBOARD_EN
    ,
    input  logic                         issueEn,
    input  logic [ADDR_W-1:0]            issueReg,
    output logic [NUM_READ-1:0]          readBusy
`endif
);

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic              wr_valid;

    assign wr_valid = writeEn && (writeReg != '0);

    // NOTE: the array is cleared on reset because software may read any register
    // right after reset and must see zero; this rules out a plain RAM macro.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < DEPTH; r++) begin
                regs_q[r] <= '0;
            end
        end else if (wr_valid) begin
            // NOTE: state updates use <= so every read in this edge sees the old values.
            regs_q[writeReg] <= writeData;
        end
    end

    // Per-port read value with write-first bypass; address 0 always yields zero.
    logic [DATA_W-1:0] rd_byp [NUM_READ];

    for (genvar p = 0; p < NUM_READ; p++) begin : g_read
        logic [ADDR_W-1:0] raddr;
        assign raddr = readReg[p*ADDR_W +: ADDR_W];

        // NOTE: every path assigns rd_byp, so no latch is inferred here.
        always_comb begin
            if (raddr == '0) begin
                rd_byp[p] = '0;
            end else if (writeEn && (writeReg == raddr)) begin
                rd_byp[p] = writeData;
            end else begin
                rd_byp[p] = regs_q[raddr];
            end
        end

        if (READ_LAT == 0) begin : g_comb
            assign readData[p*DATA_W +: DATA_W] = rd_byp[p];
        end else begin : g_reg
            logic [DATA_W-1:0] rdata_q;

            always_ff @(posedge clk) begin
                if (reset) begin
                    rdata_q <= '0;
                end else begin
                    rdata_q <= rd_byp[p];
                end
            end

            assign readData[p*DATA_W +: DATA_W] = rdata_q;
        end
    end

`ifdef REGFILE_SCOREBOARD_EN
    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    // Issue is applied after writeback so a same-cycle reissue keeps the bit set.
    always_comb begin
        busy_d = busy_q;
        if (wr_valid) begin
            busy_d[writeReg] = 1'b0;
        end
        if (issueEn && (issueReg != '0)) begin
            busy_d[issueReg] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    for (genvar p = 0; p < NUM_READ; p++) begin : g_busy
        assign readBusy[p] = busy_q[readReg[p*ADDR_W +: ADDR_W]];
    end
`endif

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: combinational and registered-read instances
// driven in parallel and compared against an array-based reference model.
module tb_register_file;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int ND = 32;

    logic               clk = 1'b0;
    logic               reset;
    logic [NR*AW-1:0]   readReg;
    logic [NR*DW-1:0]   rdata_c;
    logic [NR*DW-1:0]   rdata_r;
    logic               writeEn;
    logic [AW-1:0]      writeReg;
    logic [DW-1:0]      writeData;
`ifdef REGFILE_SCOREBOARD_EN
    logic               issueEn;
    logic [AW-1:0]      issueReg;
    logic [NR-1:0]      busy_c;
    logic [NR-1:0]      busy_r;
`endif

    always #5 clk = ~clk;

    register_file #(.DATA_W(DW), .DEPTH(ND), .ADDR_W(AW), .NUM_READ(NR), .READ_LAT(0)) dut_c (
        .clk(clk), .reset(reset), .readReg(readReg), .readData(rdata_c),
        .writeEn(writeEn), .writeReg(writeReg), .writeData(writeData)
`ifdef REGFILE_SCOREBOARD_EN
        , .issueEn(issueEn), .issueReg(issueReg), .readBusy(busy_c)
`endif
    );

    register_file #(.DATA_W(DW), .DEPTH(ND), .ADDR_W(AW), .NUM_READ(NR), .READ_LAT(1)) dut_r (
        .clk(clk), .reset(reset), .readReg(readReg), .readData(rdata_r),
        .writeEn(writeEn), .writeReg(writeReg), .writeData(writeData)
`ifdef REGFILE_SCOREBOARD_EN
        , .issueEn(issueEn), .issueReg(issueReg), .readBusy(busy_r)
`endif
    );

    int total = 0;
    int bad   = 0;

    // Reference state: architectural registers, busy bits, and the pending registered read.
    logic [DW-1:0] mem_m   [ND];
    bit            busy_m  [ND];
    logic [DW-1:0] lat_exp [NR];

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] model_read(input int a);
        if (a == 0) return '0;
        if (writeEn && int'(writeReg) == a) return writeData;
        return mem_m[a];
    endfunction

    function automatic int raddr(input int p);
        logic [NR*AW-1:0] rr;
        rr = readReg;
        return int'(rr[p*AW +: AW]);
    endfunction

    // One clock: check outputs at the falling edge, then advance the model at the rising edge.
    task automatic cycle(input string tag);
        logic [DW-1:0] exp_now [NR];
        logic [NR*DW-1:0] gc, gr;
        @(negedge clk);
        gc = rdata_c;
        gr = rdata_r;
        for (int p = 0; p < NR; p++) begin
            exp_now[p] = model_read(raddr(p));
            check($sformatf("%s_c%0d", tag, p), gc[p*DW +: DW], exp_now[p]);
            check($sformatf("%s_r%0d", tag, p), gr[p*DW +: DW], lat_exp[p]);
`ifdef REGFILE_SCOREBOARD_EN
            check($sformatf("%s_bc%0d", tag, p), {31'd0, busy_c[p]}, {31'd0, busy_m[raddr(p)]});
            check($sformatf("%s_br%0d", tag, p), {31'd0, busy_r[p]}, {31'd0, busy_m[raddr(p)]});
`endif
        end
        @(posedge clk);
        if (reset) begin
            for (int r = 0; r < ND; r++) begin
                mem_m[r]  = '0;
                busy_m[r] = 1'b0;
            end
            for (int p = 0; p < NR; p++) lat_exp[p] = '0;
        end else begin
            for (int p = 0; p < NR; p++) lat_exp[p] = exp_now[p];
            if (writeEn && writeReg != 0) begin
                mem_m[writeReg]  = writeData;
                busy_m[writeReg] = 1'b0;
            end
`ifdef REGFILE_SCOREBOARD_EN
            if (issueEn && issueReg != 0) busy_m[issueReg] = 1'b1;
`endif
        end
        #1;
    endtask

    task automatic drive(input bit rst, input bit we, input int wa, input logic [DW-1:0] wd,
                         input int r0, input int r1);
        reset     = rst;
        writeEn   = we;
        writeReg  = AW'(wa);
        writeData = wd;
        readReg   = {AW'(r1), AW'(r0)};
`ifdef REGFILE_SCOREBOARD_EN
        issueEn   = 1'b0;
        issueReg  = '0;
`endif
    endtask

    initial begin
        drive(1'b1, 1'b0, 0, '0, 0, 0);
        for (int r = 0; r < ND; r++) begin
            mem_m[r]  = '0;
            busy_m[r] = 1'b0;
        end
        for (int p = 0; p < NR; p++) lat_exp[p] = '0;
        @(posedge clk);
        #1;

        // All registers read zero after reset, on both ports.
        for (int a = 0; a < ND; a++) begin
            drive(1'b0, 1'b0, 0, '0, a, ND - 1 - a);
            cycle("rst_rd");
        end

        // Plain write then read; register 0 ignores writes.
        drive(1'b0, 1'b1, 5, 32'h0000_F0F0, 0, 0);
        cycle("wr5");
        drive(1'b0, 1'b0, 0, '0, 5, 5);
        cycle("rd5");
        drive(1'b0, 1'b0, 0, '0, 5, 0);
        cycle("rd5_lat");
        drive(1'b0, 1'b1, 0, 32'hDEAD_BEEF, 0, 0);
        cycle("wr0");
        drive(1'b0, 1'b0, 0, '0, 0, 0);
        cycle("rd0");

        // Same-cycle write-to-read bypass on both ports.
        drive(1'b0, 1'b1, 7, 32'h1234_5678, 7, 7);
        cycle("byp7");
        drive(1'b0, 1'b0, 0, '0, 7, 5);
        cycle("rd7");

        // Reset beats a simultaneous write.
        drive(1'b1, 1'b1, 3, 32'h0000_AAAA, 3, 3);
        cycle("rst_wr3");
        drive(1'b0, 1'b0, 0, '0, 3, 3);
        cycle("rd3");

        // Fill every register, then reset and confirm everything is gone.
        for (int a = 1; a < ND; a++) begin
            drive(1'b0, 1'b1, a, $urandom, a - 1, a);
            cycle("fill");
        end
        drive(1'b1, 1'b0, 0, '0, 1, 31);
        cycle("rst_mid");
        for (int a = 0; a < ND; a++) begin
            drive(1'b0, 1'b0, 0, '0, a, (a + 7) % ND);
            cycle("post_rst");
        end

`ifdef REGFILE_SCOREBOARD_EN
        // Busy scoreboard: issue, writeback clear, same-cycle issue+write, issue of reg 0.
        drive(1'b0, 1'b0, 0, '0, 9, 0);
        issueEn = 1'b1; issueReg = 5'd9;
        cycle("iss9");
        drive(1'b0, 1'b0, 0, '0, 9, 9);
        cycle("busy9");
        drive(1'b0, 1'b1, 9, 32'h0000_0099, 9, 9);
        cycle("wb9");
        drive(1'b0, 1'b0, 0, '0, 9, 9);
        cycle("free9");
        drive(1'b0, 1'b1, 9, 32'h0000_0999, 9, 9);
        issueEn = 1'b1; issueReg = 5'd9;
        cycle("iswb9");
        drive(1'b0, 1'b0, 0, '0, 9, 0);
        issueEn = 1'b1; issueReg = 5'd0;
        cycle("iss0");
        drive(1'b0, 1'b0, 0, '0, 9, 0);
        cycle("busy_hold");
`endif

        // Randomised traffic with occasional resets and deliberate address collisions.
        for (int n = 0; n < 600; n++) begin
            int wa, r0, r1;
            wa = $urandom_range(0, ND - 1);
            r0 = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, ND - 1);
            r1 = ($urandom_range(0, 3) == 0) ? r0 : $urandom_range(0, ND - 1);
            drive($urandom_range(0, 63) == 0, $urandom_range(0, 1) == 1, wa, $urandom, r0, r1);
`ifdef REGFILE_SCOREBOARD_EN
            issueEn  = $urandom_range(0, 2) == 0;
            issueReg = ($urandom_range(0, 3) == 0) ? AW'(wa) : AW'($urandom_range(0, ND - 1));
`endif
            cycle("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
